// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Optional feature macro: ARB_STARVE_GUARD_EN (fetch starvation guard).
package mem_arb_pkg;

  // Which requester owns the memory port in a given cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_DM   = 2'd2
  } port_sel_e;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH         = 16;

  // Address bits that must be zero for a legal 16-bit word access
  localparam int unsigned ALIGN_MASK = 32'h0000_0001;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and memory-side signals for the arbiter.
// slave  = arbiter view, master = requesters plus memory view.
// Optional feature macro: ARB_STARVE_GUARD_EN (no effect on this file).
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  import mem_arb_pkg::*;

  // Fetch port (read-only)
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  // Data port (read/write)
  logic                  dm_req;
  logic                  dm_wr;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_err;

  // Single-port memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_wr, dm_addr, dm_wdata,
    input  mem_data_out,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output dm_gnt, dm_rvalid, dm_rdata, dm_err,
    output mem_addr, mem_data_in, mem_enable, mem_wr
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_wr, dm_addr, dm_wdata,
    output mem_data_out,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
    input  mem_addr, mem_data_in, mem_enable, mem_wr
  );

endinterface

// File: rtl/mem_arb_rsp_stage.sv
// Response stage: carries the grant owner, error flag and read data from the
// grant cycle into the following cycle and fans them out to the two ports.
// Optional feature macro: ARB_STARVE_GUARD_EN (no effect on this file).
module mem_arb_rsp_stage
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  port_sel_e             i_sel,
  input  logic                  i_err,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_ifRvalid,
  output logic [DATA_WIDTH-1:0] o_ifRdata,
  output logic                  o_ifErr,
  output logic                  o_dmRvalid,
  output logic [DATA_WIDTH-1:0] o_dmRdata,
  output logic                  o_dmErr
);

  port_sel_e             r_sel;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Capture the outcome of this cycle's grant; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= SEL_NONE;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_sel   <= i_sel;
      r_err   <= i_err;
      r_rdata <= i_rdata;
    end
  end

  // Route the held response to its owner; a reset in the response cycle
  // also suppresses it so the requester knows to reissue
  always_comb begin
    o_ifRvalid = 1'b0;
    o_ifRdata  = '0;
    o_ifErr    = 1'b0;
    o_dmRvalid = 1'b0;
    o_dmRdata  = '0;
    o_dmErr    = 1'b0;
    if (!rst) begin
      case (r_sel)
        SEL_IF: begin
          o_ifRvalid = 1'b1;
          o_ifRdata  = r_rdata;
          o_ifErr    = r_err;
        end
        SEL_DM: begin
          o_dmRvalid = 1'b1;
          o_dmRdata  = r_rdata;
          o_dmErr    = r_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch port and the data port onto one single-port memory.
// Data has priority; the memory is driven combinationally by the winner and
// each response appears one cycle after its grant.
// Optional feature macro: ARB_STARVE_GUARD_EN -- after STARVE_LIMIT denied
// fetch cycles, fetch is forced through ahead of data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1) begin : g_badStarveLimit
    $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
  end

  port_sel_e             w_sel;
  logic                  w_forceIf;
  logic                  w_ifMis;
  logic                  w_dmMis;
  logic [ADDR_WIDTH-1:0] w_memAddr;
  logic [DATA_WIDTH-1:0] w_memDataIn;
  logic                  w_memEnable;
  logic                  w_memWr;
  logic                  w_rspErr;
  logic [DATA_WIDTH-1:0] w_rspData;

  assign w_ifMis = |(bus.if_addr & ADDR_WIDTH'(ALIGN_MASK));
  assign w_dmMis = |(bus.dm_addr & ADDR_WIDTH'(ALIGN_MASK));

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starveCnt;

  // Count consecutive cycles fetch asked and lost; saturate at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starveCnt <= '0;
    end else if (w_sel == SEL_IF) begin
      r_starveCnt <= '0;
    end else if (bus.if_req && (r_starveCnt != CNT_MAX)) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  assign w_forceIf = (r_starveCnt == CNT_MAX);
`else
  assign w_forceIf = 1'b0;
`endif

  // Pick the winner: nobody during reset, else data unless fetch is being forced
  always_comb begin
    w_sel = SEL_NONE;
    if (!rst) begin
      if (bus.dm_req && !(w_forceIf && bus.if_req)) begin
        w_sel = SEL_DM;
      end else if (bus.if_req) begin
        w_sel = SEL_IF;
      end
    end
  end

  // Steer the winner onto the memory and form the response it will see;
  // misaligned accesses are consumed without touching the memory
  always_comb begin
    w_memAddr   = '0;
    w_memDataIn = '0;
    w_memEnable = 1'b0;
    w_memWr     = 1'b0;
    w_rspErr    = 1'b0;
    w_rspData   = '0;
    case (w_sel)
      SEL_IF: begin
        w_memAddr   = bus.if_addr;
        w_memEnable = !w_ifMis;
        w_rspErr    = w_ifMis;
        w_rspData   = w_ifMis ? '0 : bus.mem_data_out;
      end
      SEL_DM: begin
        w_memAddr   = bus.dm_addr;
        w_memDataIn = bus.dm_wdata;
        w_memEnable = !w_dmMis;
        w_memWr     = bus.dm_wr && !w_dmMis;
        w_rspErr    = w_dmMis;
        w_rspData   = (w_dmMis || bus.dm_wr) ? '0 : bus.mem_data_out;
      end
      default: ;
    endcase
  end

  assign bus.if_gnt      = (w_sel == SEL_IF);
  assign bus.dm_gnt      = (w_sel == SEL_DM);
  assign bus.mem_addr    = w_memAddr;
  assign bus.mem_data_in = w_memDataIn;
  assign bus.mem_enable  = w_memEnable;
  assign bus.mem_wr      = w_memWr;

  mem_arb_rsp_stage u_rspStage (
    .clk        (clk),
    .rst        (rst),
    .i_sel      (w_sel),
    .i_err      (w_rspErr),
    .i_rdata    (w_rspData),
    .o_ifRvalid (bus.if_rvalid),
    .o_ifRdata  (bus.if_rdata),
    .o_ifErr    (bus.if_err),
    .o_dmRvalid (bus.dm_rvalid),
    .o_dmRdata  (bus.dm_rdata),
    .o_dmErr    (bus.dm_err)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a response scoreboard.
// Optional feature macro: ARB_STARVE_GUARD_EN selects the starvation scenario.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        ifV;
    logic [15:0] ifD;
    logic        ifE;
    logic        dmV;
    logic [15:0] dmD;
    logic        dmE;
  } rsp_t;

  logic clk;
  logic rst;
  logic memLoad;
  int   checks;
  int   failures;
  rsp_t sbQ[$];

  logic [15:0] mem [0:255];

  mem_port_arbiter_if #(.ADDR_WIDTH(16)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH   (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: combinational read, write on rising edge when enabled
  assign bus.mem_data_out = mem[bus.mem_addr[8:1]];

  // Load a known image while memLoad is high, otherwise behave as the memory
  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
      mem[8] <= 16'hBEEF;
    end else if (bus.mem_enable && bus.mem_wr) begin
      mem[bus.mem_addr[8:1]] <= bus.mem_data_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check grant-cycle outputs
  // and the response owed from the previous cycle, then queue the next response
  task automatic applyStimulus(input string tag, input logic rstV,
                               input logic ifReq, input logic [15:0] ifAddr,
                               input logic dmReq, input logic dmWr,
                               input logic [15:0] dmAddr, input logic [15:0] dmWdata,
                               input port_sel_e expSel, input logic [15:0] expRd);
    rsp_t        expRsp;
    rsp_t        nextRsp;
    logic [15:0] eAddr;
    logic [15:0] eDin;
    logic        eEn;
    logic        eWr;
    logic        eMis;
    @(negedge clk);
    rst         = rstV;
    bus.if_req  = ifReq;
    bus.if_addr = ifAddr;
    bus.dm_req  = dmReq;
    bus.dm_wr   = dmWr;
    bus.dm_addr = dmAddr;
    bus.dm_wdata = dmWdata;
    #1;
    eAddr = 16'h0; eDin = 16'h0; eEn = 1'b0; eWr = 1'b0; eMis = 1'b0;
    if (expSel == SEL_IF) begin
      eAddr = ifAddr; eMis = ifAddr[0]; eEn = !eMis;
    end else if (expSel == SEL_DM) begin
      eAddr = dmAddr; eDin = dmWdata; eMis = dmAddr[0]; eEn = !eMis; eWr = dmWr && !eMis;
    end
    checkOutput({tag, ".if_gnt"},      32'(bus.if_gnt),      32'(expSel == SEL_IF));
    checkOutput({tag, ".dm_gnt"},      32'(bus.dm_gnt),      32'(expSel == SEL_DM));
    checkOutput({tag, ".mem_enable"},  32'(bus.mem_enable),  32'(eEn));
    checkOutput({tag, ".mem_wr"},      32'(bus.mem_wr),      32'(eWr));
    checkOutput({tag, ".mem_addr"},    32'(bus.mem_addr),    32'(eAddr));
    checkOutput({tag, ".mem_data_in"}, 32'(bus.mem_data_in), 32'(eDin));
    if (sbQ.size() != 0) expRsp = sbQ.pop_front();
    else expRsp = '0;
    if (rstV) expRsp = '0;
    checkOutput({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(expRsp.ifV));
    checkOutput({tag, ".if_rdata"},  32'(bus.if_rdata),  32'(expRsp.ifD));
    checkOutput({tag, ".if_err"},    32'(bus.if_err),    32'(expRsp.ifE));
    checkOutput({tag, ".dm_rvalid"}, 32'(bus.dm_rvalid), 32'(expRsp.dmV));
    checkOutput({tag, ".dm_rdata"},  32'(bus.dm_rdata),  32'(expRsp.dmD));
    checkOutput({tag, ".dm_err"},    32'(bus.dm_err),    32'(expRsp.dmE));
    nextRsp = '0;
    if (!rstV) begin
      if (expSel == SEL_IF) begin
        nextRsp.ifV = 1'b1;
        nextRsp.ifE = eMis;
        nextRsp.ifD = eMis ? 16'h0 : expRd;
      end else if (expSel == SEL_DM) begin
        nextRsp.dmV = 1'b1;
        nextRsp.dmE = eMis;
        nextRsp.dmD = (eMis || dmWr) ? 16'h0 : expRd;
      end
    end
    sbQ.push_back(nextRsp);
  endtask

  // Directed sequence
  initial begin
    checks   = 0;
    failures = 0;
    memLoad  = 1'b1;
    rst      = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 16'h0;
    bus.dm_req = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
    sbQ.push_back('0);

    // Reset state, including requests held during reset
    applyStimulus("reset0", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);
    memLoad = 1'b0;
    applyStimulus("reset1", 1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0042, 16'h5555, SEL_NONE, 16'h0);
    applyStimulus("idle0",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);

    // Fetch only
    applyStimulus("fetch",  1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_IF,   16'hBEEF);
    applyStimulus("idle1",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);

    // Contention: data first, fetch next cycle, responses in that order
    applyStimulus("cont0",  1'b0, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0020, 16'h0000, SEL_DM,   16'hA010);
    applyStimulus("cont1",  1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_IF,   16'hA018);
    applyStimulus("idle2",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);

    // Write then read back, back to back
    applyStimulus("wr42",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 16'h1234, SEL_DM,   16'h0);
    applyStimulus("rd42",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 16'h0000, SEL_DM,   16'h1234);
    applyStimulus("idle3",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);

    // Misaligned fetch and misaligned write that must not reach memory
    applyStimulus("misIf",  1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_IF,   16'h0);
    applyStimulus("misDm",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0045, 16'hFFFF, SEL_DM,   16'h0);
    applyStimulus("rd44",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0044, 16'h0000, SEL_DM,   16'hA022);
    applyStimulus("rd46",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0046, 16'h0000, SEL_DM,   16'hA023);
    applyStimulus("idle4",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);

    // Reset in the response cycle suppresses the response
    applyStimulus("rstG",   1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_IF,   16'hBEEF);
    applyStimulus("rstR0",  1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0044, 16'h7777, SEL_NONE, 16'h0);
    applyStimulus("rstR1",  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);
    applyStimulus("rstI",   1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);
    applyStimulus("refetch",1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_IF,   16'hBEEF);
    applyStimulus("idle5",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);

    // Both ports held requesting for six cycles
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (i == 4)
        applyStimulus($sformatf("hold%0d", i), 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0044, 16'h0000, SEL_IF, 16'hA020);
      else
        applyStimulus($sformatf("hold%0d", i), 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0044, 16'h0000, SEL_DM, 16'hA022);
`else
      applyStimulus($sformatf("hold%0d", i), 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0044, 16'h0000, SEL_DM, 16'hA022);
`endif
    end
    applyStimulus("idle6",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, SEL_NONE, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
